bias_store: RTL and testbench

BIAS_STORE -- requirements
Module: bias_store

---
 rtl/bias_store_pkg.sv | 16 +
 rtl/bias_bank.sv | 40 ++++
 rtl/bias_store.sv | 119 +++++++++++
 tb/tb_bias_store.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bias_store_pkg.sv
// Shared widths, beat type and lane helper for the bias store.
package bias_store_pkg;

    localparam int unsigned BIAS_WIDTH       = 32;
    localparam int unsigned LANES_PER_BEAT   = 4;
    localparam int unsigned BIASES_PER_GROUP = 8;
    localparam int unsigned BEAT_WIDTH       = BIAS_WIDTH * LANES_PER_BEAT;

    typedef logic [BEAT_WIDTH-1:0] beat_t;

    // Extract lane `lane` (bits [32*lane+31:32*lane]) from a 128-bit beat.
    function automatic logic [BIAS_WIDTH-1:0] beat_lane(input beat_t b, input int unsigned lane);
        return b[lane*BIAS_WIDTH +: BIAS_WIDTH];
    endfunction

endpackage

// File: rtl/bias_bank.sv
// One bank of 128-bit bias words: single write port, registered read port.
// Storage is deliberately not reset; only the read register clears.
module bias_bank
    import bias_store_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [IDX_WIDTH-1:0] wr_idx_i,
    input  beat_t                wr_data_i,
    input  logic                 rd_en_i,
    input  logic [IDX_WIDTH-1:0] rd_idx_i,
    output beat_t                rd_data_o
);

    beat_t mem_q [DEPTH];
    beat_t rd_data_q;

    // Word storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Registered read; sees the pre-write contents on a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bias_store.sv
// Bias store: beats of four biases are appended at an auto-incrementing word
// pointer; a read returns all eight biases of one output group (words 2g and
// 2g+1) one clock later. Even words live in one bank, odd words in the other.
// Optional simulation checks are compiled in with BIAS_STORE_ASSERT_EN.
module bias_store
    import bias_store_pkg::*;
#(
    parameter int unsigned MAX_DEPTH  = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(MAX_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [BEAT_WIDTH-1:0]   wr_data,
    input  logic                    wr_addr_rst,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-2:0]   rd_group,
    output logic [BIAS_WIDTH-1:0]   bias_out [0:BIASES_PER_GROUP-1],
    output logic                    rd_valid
);

    localparam int unsigned BANK_DEPTH = MAX_DEPTH / 2;
    localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic                  rd_valid_q;
    beat_t                 rd_even;
    beat_t                 rd_odd;

    // Effective write word and next pointer; wr_addr_rst redirects this
    // cycle's write to word 0 so a combined pulse leaves the pointer at 1.
    always_comb begin
        wr_addr_c = wr_addr_rst ? '0 : wr_ptr_q;
        wr_ptr_d  = wr_addr_c;
        if (wr_en) begin
            if (wr_addr_c == ADDR_WIDTH'(MAX_DEPTH - 1)) begin
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_addr_c + ADDR_WIDTH'(1);
            end
        end
    end

    // Write pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Read-valid strobe: high exactly in the cycle after each rd_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
        end
    end

    bias_bank #(
        .DEPTH     (BANK_DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_bank_even (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (wr_en & ~wr_addr_c[0]),
        .wr_idx_i  (wr_addr_c[ADDR_WIDTH-1:1]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_group),
        .rd_data_o (rd_even)
    );

    bias_bank #(
        .DEPTH     (BANK_DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_bank_odd (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (wr_en & wr_addr_c[0]),
        .wr_idx_i  (wr_addr_c[ADDR_WIDTH-1:1]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_group),
        .rd_data_o (rd_odd)
    );

    // Fan the two bank read registers out into the eight group biases.
    always_comb begin
        for (int unsigned i = 0; i < LANES_PER_BEAT; i++) begin
            bias_out[i]                  = beat_lane(rd_even, i);
            bias_out[LANES_PER_BEAT + i] = beat_lane(rd_odd, i);
        end
    end

    assign rd_valid = rd_valid_q;

`ifdef BIAS_STORE_ASSERT_EN
    // Control inputs must be known whenever out of reset.
    a_ctrl_known: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown({wr_en, rd_en, wr_addr_rst}));

    // rd_valid only ever follows a cycle with rd_en.
    a_valid_after_rd: assert property (@(posedge clk) disable iff (!rst)
        !rd_en |=> !rd_valid);

    // Flag a silent pointer wrap, which overwrites the oldest groups.
    always_ff @(posedge clk) begin
        if (rst && wr_en && !wr_addr_rst && (wr_ptr_q == ADDR_WIDTH'(MAX_DEPTH - 1))) begin
            $warning("bias_store: write pointer wrapped to 0 without wr_addr_rst");
        end
    end
`endif

endmodule

// File: tb/tb_bias_store.sv
// Scoreboard bench for bias_store: stimulus pushes expected groups, a
// negedge monitor pops them whenever rd_valid is seen.
module tb_bias_store;

    typedef logic [255:0] grp_t;
    typedef logic [127:0] beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    beat_t       wr_data = '0;
    logic        wr_addr_rst = 1'b0;
    logic        rd_en = 1'b0;
    logic [6:0]  rd_group = '0;
    logic [31:0] bias_out [0:7];
    logic        rd_valid;

    int n_chk  = 0;
    int n_pass = 0;

    grp_t  exp_q [$];
    string tag_q [$];
    grp_t  last_exp = '0;
    logic  exp_valid = 1'b0;

    bias_store dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_addr_rst (wr_addr_rst),
        .rd_en       (rd_en),
        .rd_group    (rd_group),
        .bias_out    (bias_out),
        .rd_valid    (rd_valid)
    );

    always #5 clk = ~clk;

    function automatic grp_t pack_out();
        grp_t r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = bias_out[i];
        return r;
    endfunction

    // Fill pattern A: bias(g,i) = g<<24 | g<<16 | i<<8 | i
    function automatic logic [31:0] bias_a(input int g, input int i);
        return {8'(g), 8'(g), 8'(i), 8'(i)};
    endfunction

    // Fill pattern B used after the mid-run reset.
    function automatic logic [31:0] bias_b(input int g, input int i);
        return 32'hA500_0000 | (32'(g) << 16) | 32'(i);
    endfunction

    function automatic beat_t beat_a(input int g, input int h);
        beat_t b;
        for (int i = 0; i < 4; i++) b[32*i +: 32] = bias_a(g, 4*h + i);
        return b;
    endfunction

    function automatic beat_t beat_b(input int g, input int h);
        beat_t b;
        for (int i = 0; i < 4; i++) b[32*i +: 32] = bias_b(g, 4*h + i);
        return b;
    endfunction

    // Word k of the wrap fill.
    function automatic beat_t beat_w(input int k);
        beat_t b;
        for (int i = 0; i < 4; i++) b[32*i +: 32] = 32'h3000_0000 | (32'(k) << 8) | 32'(i);
        return b;
    endfunction

    function automatic beat_t beat_c(input logic [15:0] tag);
        beat_t b;
        for (int i = 0; i < 4; i++) b[32*i +: 32] = {tag, 16'(i)};
        return b;
    endfunction

    // Reference rd_valid: high in the cycle after any rd_en, cleared by reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) exp_valid <= 1'b0;
        else      exp_valid <= rd_en;
    end

    // Monitor: valid timing, popped read data, and hold-between-reads.
    always @(negedge clk) begin
        grp_t  e;
        string t;
        if (!rst) last_exp = '0;
        n_chk++;
        if (rd_valid === exp_valid) n_pass++;
        else $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, exp_valid, $time);
        if (rd_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_read: rd_valid with empty scoreboard at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                last_exp = e;
                if (pack_out() === e) n_pass++;
                else $display("FAIL %s: got %h expected %h", t, pack_out(), e);
            end
        end else begin
            n_chk++;
            if (pack_out() === last_exp) n_pass++;
            else $display("FAIL hold: got %h expected %h at %0t", pack_out(), last_exp, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_beat(input beat_t d, input logic arst);
        wr_en = 1'b1; wr_data = d; wr_addr_rst = arst;
        tick();
        wr_en = 1'b0; wr_addr_rst = 1'b0;
    endtask

    task automatic rd(input int g, input grp_t e, input string t);
        rd_en = 1'b1; rd_group = 7'(g);
        exp_q.push_back(e); tag_q.push_back(t);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic ptr_rst();
        wr_addr_rst = 1'b1;
        tick();
        wr_addr_rst = 1'b0;
    endtask

    function automatic grp_t grp_a(input int g);
        return {beat_a(g, 1), beat_a(g, 0)};
    endfunction

    function automatic grp_t grp_b(input int g);
        return {beat_b(g, 1), beat_b(g, 0)};
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d reads outstanding after timeout", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
        tick();
    endtask

    initial begin
        grp_t g3;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Fill groups 0-7 with pattern A right after reset.
        ptr_rst();
        for (int g = 0; g < 8; g++) begin
            wr_beat(beat_a(g, 0), 1'b0);
            wr_beat(beat_a(g, 1), 1'b0);
        end

        // Single read of group 3 with an explicit spot check of bias 5.
        g3 = grp_a(3);
        rd(3, g3, "read_g3");
        drain();
        n_chk++;
        if (bias_out[5] === 32'h0303_0505 && g3[5*32 +: 32] === 32'h0303_0505) n_pass++;
        else $display("FAIL g3_bias5: got %h expected 03030505", bias_out[5]);

        // Back-to-back reads of every group.
        for (int g = 0; g < 8; g++) rd(g, grp_a(g), "seq_read");
        drain();

        // Out-of-order reads with idle gaps (exercises hold).
        rd(5, grp_a(5), "ooo_g5"); tick();
        rd(2, grp_a(2), "ooo_g2"); tick();
        rd(7, grp_a(7), "ooo_g7"); tick();
        rd(0, grp_a(0), "ooo_g0");
        drain();
        n_chk++;
        if (bias_out[0] === 32'h0000_0000 && bias_out[4] === 32'h0000_0404) n_pass++;
        else $display("FAIL g0_spot: got %h/%h expected 00000000/00000404", bias_out[0], bias_out[4]);

        // Mid-run reset clears outputs; refill with pattern B.
        rst = 1'b0;
        #2;
        n_chk++;
        if (pack_out() === '0 && rd_valid === 1'b0) n_pass++;
        else $display("FAIL midrun_reset: got %h valid %b expected 0", pack_out(), rd_valid);
        tick(); tick();
        rst = 1'b1;
        for (int g = 0; g < 8; g++) begin
            wr_beat(beat_b(g, 0), 1'b0);
            wr_beat(beat_b(g, 1), 1'b0);
        end
        for (int g = 0; g < 8; g++) rd(g, grp_b(g), "refill_read");
        drain();

        // wr_addr_rst together with wr_en: beats land at words 0 and 1.
        wr_beat(beat_c(16'h1111), 1'b1);
        wr_beat(beat_c(16'h2222), 1'b0);
        rd(0, {beat_c(16'h2222), beat_c(16'h1111)}, "combo_rst_g0");
        rd(1, grp_b(1), "combo_rst_g1");
        drain();

        // 256 beats then one extra: extra overwrites word 0.
        ptr_rst();
        for (int k = 0; k < 256; k++) wr_beat(beat_w(k), 1'b0);
        wr_beat(beat_c(16'hEEEE), 1'b0);
        rd(0,   {beat_w(1),   beat_c(16'hEEEE)}, "wrap_g0");
        rd(1,   {beat_w(3),   beat_w(2)},        "wrap_g1");
        rd(127, {beat_w(255), beat_w(254)},      "wrap_g127");
        drain();

        // Same-cycle read and write of word 1: read returns old contents.
        wr_en = 1'b1; wr_data = beat_c(16'h7777);
        rd(0, {beat_w(1), beat_c(16'hEEEE)}, "rbw_old");
        wr_en = 1'b0;
        rd(0, {beat_c(16'h7777), beat_c(16'hEEEE)}, "rbw_new");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
